// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the serial FIR MAC controller: state encoding,
// default geometry and the accumulator width rule.
package fir_ctrl_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int LENGTH_DEF = 100;

    // State encoding. Kept as plain constants so external tools and
    // checkers can decode the exported state value without a typedef.
    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_MAC  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Accumulator width: full product width plus 6 guard bits for the sum.
    function automatic int acc_w(input int width);
        return 2 * width + 6;
    endfunction

endpackage

// File: rtl/fir_mac_watchdog.sv
// MAC-cycle watchdog: counts cycles spent in MAC since the last LOAD and
// flags when the LENGTH-th MAC cycle passes without the tap counter
// reporting its last tap. Only instantiated when FIR_MAC_CTRL_WATCHDOG_EN
// is defined.
module fir_mac_watchdog
#(
    parameter int  LENGTH = 100,
    localparam int CW     = $clog2(LENGTH + 1)
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    logic [CW-1:0] cnt;

    // Cycle counter: restarts on clear, advances once per MAC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires during the LENGTH-th MAC cycle; the controller gives a real
    // rollBack in that same cycle priority over this flag.
    assign expire = tick && (cnt == CW'(LENGTH - 1));

endmodule

// File: rtl/fir_mac_controller.sv
// Sequencing FSM for the serial FIR MAC datapath. Accepts one sample,
// shifts it in, clears the accumulator, runs LENGTH MAC cycles, captures
// the sum on the tap-counter rollback and offers it on the output port.
// Optional feature macro: FIR_MAC_CTRL_WATCHDOG_EN (MAC-cycle watchdog,
// sticky err). Without it err is tied low and MAC waits for dp_rollBack.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE; in_valid elsewhere is
// ignored and the source must hold it. out_valid is high only in DONE,
// out_data is stable while out_valid is high and keeps the last result
// afterwards; out_ready outside DONE is ignored.
module fir_mac_controller
    import fir_ctrl_pkg::*;
#(
    parameter int  WIDTH  = WIDTH_DEF,
    parameter int  LENGTH = LENGTH_DEF,
    localparam int ACC_W  = acc_w(WIDTH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             dp_rollBack,
    input  logic [ACC_W-1:0] dp_out,
    output logic             dp_rst,
    output logic             dp_shift_enb,
    output logic             dp_count_enb,
    output logic             register_enb,
    output logic             resetReg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             err,
    output logic [2:0]       state_dbg
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       wd_expire;

`ifdef FIR_MAC_CTRL_WATCHDOG_EN
    fir_mac_watchdog #(.LENGTH(LENGTH)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_LOAD),
        .tick   (state == ST_MAC),
        .expire (wd_expire)
    );

    // Sticky error: set when the watchdog aborts a MAC run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == ST_MAC && !dp_rollBack && wd_expire) begin
            err <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    // State register; reset lands in INIT so the datapath is resynchronised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: state_nxt = ST_IDLE;
            ST_IDLE: if (in_valid) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_MAC;
            ST_MAC: begin
                if (dp_rollBack) begin
                    state_nxt = ST_DONE;
                end else if (wd_expire) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Result capture: the adder output on the last-tap cycle is the full sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (state == ST_MAC && dp_rollBack) begin
            out_data <= dp_out;
        end
    end

    // Moore strobe decode.
    assign dp_rst       = (state == ST_INIT);
    assign in_ready     = (state == ST_IDLE);
    assign dp_shift_enb = (state == ST_LOAD);
    assign resetReg     = (state == ST_LOAD);
    assign dp_count_enb = (state == ST_MAC);
    assign register_enb = (state == ST_MAC);
    assign out_valid    = (state == ST_DONE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_fir_mac_controller.sv
// Bench for fir_mac_controller: drives a behavioural serial datapath
// (register file, coefficient ROM, tap counter, accumulator) and checks
// results against a direct convolution over the accepted sample history.
module tb_fir_mac_controller;
    import fir_ctrl_pkg::*;

    localparam int WIDTH  = 8;
    localparam int LENGTH = 100;
    localparam int ACC_W  = 2 * WIDTH + 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             dp_rollBack;
    logic [ACC_W-1:0] dp_out;
    logic             dp_rst;
    logic             dp_shift_enb;
    logic             dp_count_enb;
    logic             register_enb;
    logic             resetReg;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic             err;
    logic [2:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_controller #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dp_rollBack  (dp_rollBack),
        .dp_out       (dp_out),
        .dp_rst       (dp_rst),
        .dp_shift_enb (dp_shift_enb),
        .dp_count_enb (dp_count_enb),
        .register_enb (register_enb),
        .resetReg     (resetReg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .err          (err),
        .state_dbg    (state_dbg)
    );

    // ---------------- behavioural datapath ----------------
    logic signed [WIDTH-1:0] rom  [LENGTH];
    logic signed [WIDTH-1:0] regf [LENGTH];
    logic signed [WIDTH-1:0] smp = '0;
    logic signed [ACC_W-1:0] acc = '0;
    logic signed [ACC_W-1:0] dp_sum;
    int tap = 0;
    bit no_rb = 1'b0;

    assign dp_sum      = acc + regf[tap] * rom[tap];
    assign dp_out      = dp_sum;
    assign dp_rollBack = (tap == LENGTH - 1) && !no_rb;

    always @(posedge clk) begin
        if (dp_rst) begin
            for (int i = 0; i < LENGTH; i++) regf[i] <= '0;
            tap <= 0;
        end else begin
            if (dp_shift_enb) begin
                regf[0] <= smp;
                for (int i = 1; i < LENGTH; i++) regf[i] <= regf[i-1];
            end
            if (dp_count_enb) tap <= (tap == LENGTH - 1) ? 0 : tap + 1;
        end
        if (resetReg) acc <= '0;
        else if (register_enb) acc <= dp_sum;
    end

    // ---------------- reference model ----------------
    logic signed [WIDTH-1:0] hist[$];

    function automatic logic [ACC_W-1:0] ref_y();
        longint s = 0;
        foreach (hist[k]) s += longint'(hist[k]) * longint'(rom[k]);
        return ACC_W'(s);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic signed [WIDTH-1:0] s, output int acc_cyc, output bit to);
        to = 1'b1;
        acc_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        if (!to) begin
            smp = s;
            in_valid = 1'b1;
            acc_cyc = cyc;
            @(posedge clk);
            #1 in_valid = 1'b0;
            hist.push_front(s);
            if (hist.size() > LENGTH) void'(hist.pop_back());
        end
    endtask

    task automatic wait_out_valid(output int seen_cyc, output bit to);
        to = 1'b1;
        seen_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                to = 1'b0;
                seen_cyc = cyc;
                break;
            end
        end
    endtask

    // One sample through the pipe with out_ready high; checks result and latency.
    task automatic run_one(input string nm, input logic signed [WIDTH-1:0] s);
        int a, b;
        bit to;
        logic [ACC_W-1:0] exp_v;
        send(s, a, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s accept timeout", nm);
            return;
        end
        exp_v = ref_y();
        wait_out_valid(b, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s out_valid timeout", nm);
            return;
        end
        checks++;
        if (out_data !== exp_v) begin
            errors++;
            $display("FAIL %s data got %0d expected %0d", nm,
                     $signed(out_data), $signed(exp_v));
        end
        checks++;
        if (b - a !== LENGTH + 2) begin
            errors++;
            $display("FAIL %s latency got %0d expected %0d", nm, b - a, LENGTH + 2);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dp_rst, in_ready, dp_shift_enb, dp_count_enb, register_enb,
                 resetReg, out_valid, err} !== 8'b1000_0000 || out_data !== '0) begin
                errors++;
                $display("FAIL reset_outputs got strobes=%b data=%0h expected 10000000 data=0",
                         {dp_rst, in_ready, dp_shift_enb, dp_count_enb, register_enb,
                          resetReg, out_valid, err}, out_data);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (dp_rst !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got dp_rst=%b in_ready=%b expected 1 0", dp_rst, in_ready);
        end
        @(negedge clk);
        checks++;
        if (dp_rst !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle got dp_rst=%b in_ready=%b expected 0 1", dp_rst, in_ready);
        end
    endtask

    task automatic test_impulse();
        for (int k = 0; k < LENGTH; k++) begin
            logic signed [ACC_W-1:0] c;
            run_one("impulse", (k == 0) ? 8'sd1 : 8'sd0);
            c = rom[k];
            checks++;
            if (out_data !== c) begin
                errors++;
                $display("FAIL impulse_coeff k=%0d got %0d expected %0d", k, $signed(out_data), c);
            end
        end
    endtask

    task automatic test_full_scale();
        longint s = 0;
        logic [ACC_W-1:0] exp_v;
        for (int k = 0; k < LENGTH; k++) s += longint'(rom[k]);
        exp_v = ACC_W'(-128 * s);
        for (int k = 0; k < LENGTH; k++) run_one("full_scale", 8'sh80);
        checks++;
        if (out_data !== exp_v) begin
            errors++;
            $display("FAIL full_scale_sum got %0d expected %0d", $signed(out_data), $signed(exp_v));
        end
    endtask

    task automatic test_backpressure();
        int a, b;
        bit to;
        logic [ACC_W-1:0] exp_v;
        out_ready = 1'b0;
        send(8'($urandom_range(0, 255)), a, to);
        exp_v = ref_y();
        wait_out_valid(b, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL backpressure out_valid timeout");
            out_ready = 1'b1;
            return;
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_v) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got v=%b r=%b d=%0d expected 1 0 %0d",
                         i, out_valid, in_ready, $signed(out_data), $signed(exp_v));
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== exp_v) begin
            errors++;
            $display("FAIL backpressure_release got v=%b r=%b d=%0d expected 0 1 %0d",
                     out_valid, in_ready, $signed(out_data), $signed(exp_v));
        end
    endtask

    task automatic test_back_to_back();
        int a, prev_a, b;
        bit to;
        prev_a = -1;
        for (int n = 0; n < 4; n++) begin
            send(8'($urandom_range(0, 255)), a, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL back_to_back accept timeout");
                return;
            end
            if (prev_a >= 0) begin
                checks++;
                if (a - prev_a !== LENGTH + 3) begin
                    errors++;
                    $display("FAIL back_to_back interval got %0d expected %0d", a - prev_a, LENGTH + 3);
                end
            end
            prev_a = a;
            checks++;
            wait_out_valid(b, to);
            if (to || out_data !== ref_y()) begin
                errors++;
                $display("FAIL back_to_back data got %0d expected %0d", $signed(out_data), $signed(ref_y()));
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int a, seen;
        bit to;
        send(8'($urandom_range(0, 255)), a, to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dp_count_enb === 1'b1 && tap == 50) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to) begin
            errors++;
            $display("FAIL reset_mid_mac tap 50 not reached");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dp_rst !== 1'b1 || dp_count_enb !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_mac_abort got dp_rst=%b cnt=%b v=%b d=%0h expected 1 0 0 0",
                     dp_rst, dp_count_enb, out_valid, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_mac_no_output got %0d valid cycles expected 0", seen);
        end
        run_one("reset_recover", 8'($urandom_range(0, 255)));
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int d;
            run_one("random", 8'($urandom_range(0, 255)));
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_quiet got %b expected 0", err);
        end
    endtask

`ifdef FIR_MAC_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        int a, mac_cyc, vseen;
        bit to;
        no_rb = 1'b1;
        send(8'sd5, a, to);
        mac_cyc = 0;
        vseen = 0;
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dp_count_enb === 1'b1) mac_cyc++;
            if (out_valid === 1'b1) vseen++;
            if (err === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || mac_cyc !== LENGTH || state_dbg !== ST_INIT || vseen !== 0) begin
            errors++;
            $display("FAIL watchdog got to=%b mac=%0d state=%0d valid=%0d expected 0 %0d %0d 0",
                     to, mac_cyc, state_dbg, vseen, LENGTH, ST_INIT);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_recover got in_ready=%b err=%b expected 1 1", in_ready, err);
        end
        no_rb = 1'b0;
        hist.delete();
        run_one("watchdog_after", 8'($urandom_range(0, 255)));
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < LENGTH; k++) rom[k] = 8'($urandom_range(0, 255));
        test_reset();
        test_impulse();
        test_full_scale();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mac();
        test_random();
`ifdef FIR_MAC_CTRL_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
